sc_rr_slave_arbiter: RTL and testbench

//  Round-robin arbiter that shares one slave port between N_MASTERS requesters using the sc req/ack bus.
//  - Sits in front of each sc_slave_dev, one instance per slave, in the sc_sys_core fabric.
//  - Picks one requesting master, registers its address/cmd/wdata and drives the slave with them.
//  - Routes the slave's ack/rdata back to the granted master, then moves priority to the next master.

---
 rtl/sc_rr_slave_arbiter.sv | 97 +++++++++
 tb/tb_sc_rr_slave_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sc_rr_slave_arbiter.sv
// sc_rr_slave_arbiter: round-robin arbiter sharing one sc slave port among N_MASTERS requesters.
// Optional busy watchdog enabled by defining SC_ARB_TIMEOUT_EN.
module sc_rr_slave_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_MASTERS-1:0]  i_m_req,
    input  logic [N_MASTERS*AW-1:0] i_m_addr,
    input  logic [N_MASTERS-1:0]  i_m_cmd,
    input  logic [N_MASTERS*DW-1:0] i_m_wdata,
    output logic [N_MASTERS-1:0]  o_m_ack,
    output logic [DW-1:0]         o_m_rdata,
    output logic                  o_s_req,
    output logic [AW-1:0]         o_s_addr,
    output logic                  o_s_cmd,
    output logic [DW-1:0]         o_s_wdata,
    input  logic                  i_s_ack,
    input  logic [DW-1:0]         i_s_rdata,
    output logic [N_MASTERS-1:0]  o_grant,
    output logic                  o_err
);
    localparam int   IW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic          state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, gidx_q, gidx_d, win_idx, cand;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          cmd_q, cmd_d;
    logic          busy, take, tmo, done;

    assign busy = state_q == BUSY;
    assign take = !busy && |i_m_req;
    assign done = busy && (i_s_ack || tmo);

    // Scan offsets high to low so the smallest offset from ptr overwrites last and wins.
    always_comb begin
        win_idx = ptr_q;
        cand    = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr_q) + i) % N_MASTERS);
            if (i_m_req[cand]) win_idx = cand;
        end
    end

`ifdef SC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= busy ? cnt_q + 1'b1 : '0;
    assign tmo = busy && !i_s_ack && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = take ? BUSY : done ? IDLE : state_q;
        ptr_d   = !done ? ptr_q : gidx_q == IW'(N_MASTERS - 1) ? '0 : gidx_q + 1'b1;
        gidx_d  = take ? win_idx : gidx_q;
        addr_d  = take ? i_m_addr[win_idx*AW +: AW] : addr_q;
        wdata_d = take ? i_m_wdata[win_idx*DW +: DW] : wdata_q;
        cmd_d   = take ? i_m_cmd[win_idx] : cmd_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cmd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cmd_q   <= cmd_d;
        end
    end

    assign o_s_req   = busy;
    assign o_s_addr  = addr_q;
    assign o_s_cmd   = cmd_q;
    assign o_s_wdata = wdata_q;
    assign o_grant   = busy ? N_MASTERS'(1) << gidx_q : '0;
    assign o_m_ack   = done ? o_grant : '0;
    assign o_m_rdata = (busy && i_s_ack) ? i_s_rdata : tmo ? DW'(32'hDEAD_BEEF) : '0;
    assign o_err     = tmo;
endmodule

// File: tb/tb_sc_rr_slave_arbiter.sv
// tb_sc_rr_slave_arbiter: directed self-checking bench for sc_rr_slave_arbiter (2 masters).
module tb_sc_rr_slave_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_cmd, m_ack, grant;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic        s_req, s_cmd, s_ack, err;
    int          tests = 0;
    int          fails = 0;

    sc_rr_slave_arbiter #(.N_MASTERS(2), .AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m_req(m_req), .i_m_addr(m_addr), .i_m_cmd(m_cmd), .i_m_wdata(m_wdata),
        .o_m_ack(m_ack), .o_m_rdata(m_rdata),
        .o_s_req(s_req), .o_s_addr(s_addr), .o_s_cmd(s_cmd), .o_s_wdata(s_wdata),
        .i_s_ack(s_ack), .i_s_rdata(s_rdata),
        .o_grant(grant), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Entered in IDLE with requests driven; leaves in the following IDLE cycle with req_after driven.
    task automatic serve(input logic [1:0] g, input logic cmd, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [1:0] req_after);
        tick;
        chk("grant", grant, g);
        chk("s_req", s_req, 1);
        chk("s_cmd", s_cmd, cmd);
        chk("s_wdata", s_wdata, wd);
        s_ack = 1'b1;
        s_rdata = rd;
        #1;
        chk("m_ack", m_ack, g);
        chk("m_rdata", m_rdata, rd);
        m_req = req_after;
        tick;
        s_ack = 1'b0;
        #1;
        chk("idle_grant", grant, 0);
        chk("idle_s_req", s_req, 0);
    endtask

    initial begin
        rst = 1'b1;
        m_req = 2'b11;
        m_cmd = 2'b10;
        m_addr = {32'h20, 32'h10};
        m_wdata = {32'hCAFE, 32'h5555};
        s_ack = 1'b0;
        s_rdata = '0;
        repeat (3) tick;
        chk("rst_s_req", s_req, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_cmd", s_cmd, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        m_req = 2'b00;
        s_ack = 1'b1;
        s_rdata = 32'hAAAA;
        #1;
        chk("idle_ack_ignored", m_ack, 0);
        chk("idle_rdata_zero", m_rdata, 0);
        s_ack = 1'b0;
        // Single read from m0, slave acks two cycles after o_s_req rises.
        m_req = 2'b01;
        tick;
        chk("rd_s_req", s_req, 1);
        chk("rd_s_addr", s_addr, 32'h10);
        chk("rd_s_cmd", s_cmd, 0);
        chk("rd_grant", grant, 2'b01);
        chk("rd_no_ack", m_ack, 0);
        tick;
        chk("rd_wait_ack", m_ack, 0);
        tick;
        s_ack = 1'b1;
        s_rdata = 32'h1234_5678;
        m_req = 2'b00;
        #1;
        chk("rd_m_ack", m_ack, 2'b01);
        chk("rd_m_rdata", m_rdata, 32'h1234_5678);
        tick;
        s_ack = 1'b0;
        #1;
        chk("rd_done_s_req", s_req, 0);
        chk("rd_done_grant", grant, 0);
        // ptr is now 1, so m1 wins a tie.
        m_req = 2'b11;
        serve(2'b10, 1'b1, 32'hCAFE, 32'h1, 2'b00);
        // Request dropped mid-transaction still completes.
        m_req = 2'b01;
        tick;
        chk("drop_grant", grant, 2'b01);
        m_req = 2'b00;
        tick;
        s_ack = 1'b1;
        #1;
        chk("drop_m_ack", m_ack, 2'b01);
        tick;
        s_ack = 1'b0;
        // Contention from reset: m0 first, then m1 write after one idle cycle.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_req = 2'b11;
        serve(2'b01, 1'b0, 32'h5555, 32'h2, 2'b10);
        serve(2'b10, 1'b1, 32'hCAFE, 32'h3, 2'b00);
        // Fairness with both masters requesting continuously.
        m_req = 2'b11;
        for (int i = 0; i < 6; i++)
            serve(i[0] ? 2'b10 : 2'b01, i[0], i[0] ? 32'hCAFE : 32'h5555, 32'h100 + i, (i == 5) ? 2'b00 : 2'b11);
        // Reset during BUSY, one cycle before the slave would ack.
        m_req = 2'b10;
        tick;
        chk("mid_grant", grant, 2'b10);
        tick;
        rst = 1'b1;
        s_ack = 1'b1;
        m_req = 2'b11;
        #1;
        chk("mid_s_req", s_req, 0);
        chk("mid_grant_clr", grant, 0);
        chk("mid_no_ack", m_ack, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("mid_late_ack", m_ack, 0);
        s_ack = 1'b0;
        tick;
        chk("mid_next_grant", grant, 2'b01);
        s_ack = 1'b1;
        m_req = 2'b00;
        #1;
        chk("mid_next_ack", m_ack, 2'b01);
        tick;
        s_ack = 1'b0;
`ifdef SC_ARB_TIMEOUT_EN
        m_req = 2'b01;
        tick;
        repeat (6) tick;
        chk("to_busy7_err", err, 0);
        chk("to_busy7_ack", m_ack, 0);
        tick;
        chk("to_m_ack", m_ack, 2'b01);
        chk("to_m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("to_err", err, 1);
        tick;
        chk("to_idle_s_req", s_req, 0);
        chk("to_idle_err", err, 0);
        chk("to_idle_grant", grant, 0);
        tick;
        chk("to_regrant", grant, 2'b01);
        s_ack = 1'b1;
        m_req = 2'b00;
        #1;
        chk("to_regrant_ack", m_ack, 2'b01);
        tick;
        s_ack = 1'b0;
`else
        m_req = 2'b01;
        tick;
        repeat (20) tick;
        chk("wait_s_req", s_req, 1);
        chk("wait_err", err, 0);
        chk("wait_ack", m_ack, 0);
        s_ack = 1'b1;
        m_req = 2'b00;
        #1;
        chk("wait_m_ack", m_ack, 2'b01);
        tick;
        s_ack = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
